// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: tracks the control unit's one-hot phase enables,
// counts retired instructions, raises halt and a sticky protocol error. Optional: SINGLE_STEP_EN.
module phase_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        p1,
    input  logic        p2,
    input  logic        p3,
    input  logic        p4,
    input  logic        p5,
    input  logic        stall,
    input  logic        halt_req,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [2:0]  phase,
    output logic        halt,
    output logic [15:0] instr_count,
    output logic        phase_err
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } phase_t;

    phase_t      state;
    phase_t      state_next;
    logic [4:0]  en;
    logic        vec_idle;
    logic        vec_valid;
    logic        illegal_state;
    logic        err_set;
    logic        advance;
    logic        retire;
    logic        go;
    logic        halt_pending;

    assign en = {p5, p4, p3, p2, p1};

    // Vector decode against the current phase; codes 5..7 are flagged here and recovered below
    always_comb begin
        vec_idle      = (en == '0);
        vec_valid     = 1'b0;
        illegal_state = 1'b0;
        case (state)
            FETCH:     vec_valid = (en == 5'b00001);
            DECODE:    vec_valid = (en == 5'b00010);
            EXECUTE:   vec_valid = (en == 5'b00100);
            MEMORY:    vec_valid = (en == 5'b01000);
            WRITEBACK: vec_valid = (en == 5'b10000);
            default:   illegal_state = 1'b1;
        endcase
        err_set = illegal_state | (!vec_idle && !vec_valid);
        advance = vec_valid && !stall && !phase_err && go;
        retire  = advance && (state == WRITEBACK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (illegal_state) begin
            state_next = FETCH;
        end else if (advance) begin
            case (state)
                FETCH:     state_next = DECODE;
                DECODE:    state_next = EXECUTE;
                EXECUTE:   state_next = MEMORY;
                MEMORY:    state_next = WRITEBACK;
                default:   state_next = FETCH;
            endcase
        end
    end

    always_comb begin
        phase = state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_count  <= '0;
            halt         <= 1'b0;
            phase_err    <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            halt <= retire && halt_pending;
            if (retire) begin
                instr_count <= instr_count + 16'd1;
            end
            if (err_set) begin
                phase_err <= 1'b1;
            end
            // p2 cannot be the sole enable on a retiring edge, so clear and set never collide
            if (retire) begin
                halt_pending <= 1'b0;
            end else if (p2 && halt_req) begin
                halt_pending <= 1'b1;
            end
        end
    end

`ifdef SINGLE_STEP_EN
    logic step_meta;
    logic step_sync;
    logic step_prev;
    logic credit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
            credit    <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
            if (retire) begin
                credit <= 1'b0;
            end else if (step_sync && !step_prev && (state == FETCH)) begin
                credit <= 1'b1;
            end
        end
    end

    assign go = credit;
`else
    assign go = 1'b1;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized and directed bench for phase_sequencer against a behavioural phase model.
// Build with +define+SINGLE_STEP_EN to exercise the single-step variant.
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        p1, p2, p3, p4, p5;
    logic        stall;
    logic        halt_req;
    logic        step;
    logic [2:0]  phase;
    logic        halt;
    logic [15:0] instr_count;
    logic        phase_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_phase;
    int m_count;
    bit m_err;
    bit m_pend;
    bit m_halt;
    bit m_credit;
    bit s1, s2, s3;

    phase_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .p5          (p5),
        .stall       (stall),
        .halt_req    (halt_req),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .phase       (phase),
        .halt        (halt),
        .instr_count (instr_count),
        .phase_err   (phase_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic [4:0] v);
        {p5, p4, p3, p2, p1} = v;
    endtask

    task automatic drive_match();
        logic [4:0] v;
        v = 5'd1 << m_phase;
        set_en(v);
    endtask

    task automatic model_clear();
        m_phase = 0; m_count = 0; m_err = 0; m_pend = 0; m_halt = 0;
        m_credit = 0; s1 = 0; s2 = 0; s3 = 0;
    endtask

    // One rising edge of the specification's rules, applied to the currently driven inputs
    task automatic model_edge();
        logic [4:0] en;
        bit valid, idle, adv, ok, set_credit, retired;
        en = {p5, p4, p3, p2, p1};
        idle  = (en == 5'd0);
        valid = ($countones(en) == 1) && en[m_phase];
`ifdef SINGLE_STEP_EN
        ok = m_credit;
        set_credit = s2 && !s3 && (m_phase == 0);
        s3 = s2; s2 = s1; s1 = step;
`else
        ok = 1;
        set_credit = 0;
`endif
        adv = valid && !stall && !m_err && ok;
        retired = 0;
        m_halt = 0;
        if (!idle && !valid) m_err = 1;
        if (adv) begin
            if (m_phase == 4) begin
                retired = 1;
                m_phase = 0;
                m_count = (m_count + 1) % 65536;
                if (m_pend) begin
                    m_halt = 1;
                    m_pend = 0;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (p2 && halt_req) m_pend = 1;
        if (retired) m_credit = 0;
        else if (set_credit) m_credit = 1;
    endtask

    task automatic check_all(input string where);
        check_eq({where, ".phase"}, 32'(phase), 32'(m_phase));
        check_eq({where, ".halt"}, 32'(halt), 32'(m_halt));
        check_eq({where, ".count"}, 32'(instr_count), 32'(m_count));
        check_eq({where, ".err"}, 32'(phase_err), 32'(m_err));
    endtask

    task automatic cycle(input string where);
        @(posedge clock);
        model_edge();
        #1;
        check_all(where);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge
    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_clear();
        check_all("reset");
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_match(input int n, input string where);
        for (int i = 0; i < n; i++) begin
            drive_match();
            cycle(where);
        end
    endtask

    initial begin
        reset = 1'b0;
        set_en(5'd0);
        stall = 0; halt_req = 0; step = 0;
        model_clear();
        @(negedge clock);
        @(negedge clock);
        check_all("por");
        reset = 1'b1;

`ifdef SINGLE_STEP_EN
        // No credit: valid enables must not move the phase
        run_match(6, "nostep");
        check_eq("nostep_phase", 32'(phase), 32'd0);
        for (int k = 1; k <= 2; k++) begin
            step = 1;
            drive_match();
            cycle("step_hi");
            step = 0;
            run_match(12, "step_run");
            check_eq("step_count", 32'(instr_count), 32'(k));
            check_eq("step_rest", 32'(phase), 32'd0);
        end
`else
        // Free-run ten instructions
        run_match(50, "free");
        check_eq("free_count", 32'(instr_count), 32'd10);
        check_eq("free_phase", 32'(phase), 32'd0);

        // Stall three cycles at phase 3
        run_match(3, "to3");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_match();
            cycle("stall");
            check_eq("stall_hold", 32'(phase), 32'd3);
        end
        stall = 0;
        run_match(1, "unstall");
        check_eq("unstall_phase", 32'(phase), 32'd4);
        check_eq("unstall_count", 32'(instr_count), 32'd10);
        run_match(1, "retire11");
        check_eq("retire11_count", 32'(instr_count), 32'd11);

        // Halt requested while decoding instruction 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            for (int ph = 0; ph < 5; ph++) begin
                halt_req = (i == 4) && (ph == 1);
                drive_match();
                cycle("halt_run");
            end
        end
        halt_req = 0;
        check_eq("halt_pulse", 32'(halt), 32'd1);
        check_eq("halt_count", 32'(instr_count), 32'd5);
        set_en(5'd0);
        cycle("halt_after");
        check_eq("halt_drop", 32'(halt), 32'd0);

        // Protocol error: p3 while in phase 1
        do_reset();
        run_match(1, "pe_adv");
        set_en(5'b00100);
        cycle("pe_bad");
        check_eq("pe_flag", 32'(phase_err), 32'd1);
        run_match(3, "pe_frozen");
        check_eq("pe_phase", 32'(phase), 32'd1);
        do_reset();
        check_eq("pe_clear", 32'(phase_err), 32'd0);

        // Counter wrap from a preloaded 0xFFFF
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        m_count = 65535;
        run_match(5, "wrap");
        check_eq("wrap_count", 32'(instr_count), 32'd0);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 85) drive_match();
            else if (r < 94) set_en(5'd0);
            else if (r < 96) set_en(5'($urandom_range(1, 31)));
            else drive_match();
            stall    = ($urandom_range(0, 99) < 20);
            halt_req = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 8) step = ~step;
            cycle("rand");
            if ((m_err && $urandom_range(0, 9) == 0) || (c % 500 == 499)) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
